// File: rtl/inst_mem_ctrl.sv
// Instruction memory with a valid/ready fetch port, programmable wait states
// and a boot-load write port that shares the array with the fetch path.
module inst_mem_ctrl #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_LOG2  = 16,
    parameter int                    WAIT_STATES = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'hE1A00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReqValid,
    input  logic [31:0]           ReqAddr,
    output logic                  ReqReady,
    input  logic                  Flush,
    output logic                  InstValid,
    output logic [DATA_WIDTH-1:0] Inst,
    output logic                  Fault,
    input  logic                  LdEn,
    input  logic [31:0]           LdAddr,
    input  logic [DATA_WIDTH-1:0] LdData,
    output logic                  LdBusy,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  fault_q, fault_d;

    logic        accept;
    logic        enter_resp;
    logic        rd_fault;
    logic [31:0] rd_addr;
    logic        ld_we;
    logic        unused_ld;

    // Handshake: a fetch is accepted at the rising edge where ReqValid && ReqReady;
    // the response is a one-cycle InstValid pulse carrying Inst and Fault.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE:  ReqReady = ~LdEn;
            S_RESP:  ReqReady = 1'b1;
            default: ReqReady = 1'b0;
        endcase
        accept  = ReqValid && ReqReady;
        rd_addr = accept ? ReqAddr : addr_q;

        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            addr_d = ReqAddr;
            cnt_d  = WS;
            if (WAIT_STATES != 0) begin
                state_d = S_WAIT;
            end else begin
                state_d    = S_RESP;
                enter_resp = 1'b1;
            end
        end

        rd_fault = (rd_addr[1:0] != 2'b00) || (rd_addr[31:DEPTH_LOG2+2] != '0);
        if (enter_resp) begin
            fault_d = rd_fault;
            inst_d  = rd_fault ? NOP_WORD : mem[rd_addr[DEPTH_LOG2+1:2]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Loads are only honoured in IDLE, so a write never races a fetch read.
    assign ld_we     = LdEn && (state_q == S_IDLE) && (LdAddr[31:DEPTH_LOG2+2] == '0);
    assign unused_ld = ^LdAddr[1:0];

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[LdAddr[DEPTH_LOG2+1:2]] <= LdData;
        end
    end

    assign InstValid = (state_q == S_RESP) && !Flush;
    assign Inst      = inst_q;
    assign Fault     = fault_q;
    assign LdBusy    = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule
